// File: rtl/anc_sample_deinterleaver.sv
// Deinterleaves a word-serial SI/SQ/NI/NQ ADC stream into parallel samples; sigEnable one cycle after word 3, no backpressure.
// Aborts and counts frames that are broken by a misplaced marker or a stall; ANC_OFFSET_BINARY_EN flips each word's MSB on entry.
module anc_sample_deinterleaver #(
    parameter int DATA_BUS_SIZE  = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic        [DATA_BUS_SIZE-1:0] adc_data,
    input  logic                            adc_valid,
    input  logic                            adc_first,
    output logic signed [DATA_BUS_SIZE-1:0] signalChannel_I,
    output logic signed [DATA_BUS_SIZE-1:0] signalChannel_Q,
    output logic signed [DATA_BUS_SIZE-1:0] noiseChannel_I,
    output logic signed [DATA_BUS_SIZE-1:0] noiseChannel_Q,
    output logic                            sigEnable,
    output logic                            frame_error,
    output logic        [15:0]              dropped_frames
);

    typedef enum logic {SYNC_WAIT, COLLECT} state_t;

    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                   state, state_nxt;
    logic [1:0]               index, index_nxt;
    logic [15:0]              idle_cnt, idle_cnt_nxt;
    logic [DATA_BUS_SIZE-1:0] slot [4];
    logic [DATA_BUS_SIZE-1:0] word_in;
    logic [1:0]               wr_idx;
    logic                     store, abort, complete, complete_q;

`ifdef ANC_OFFSET_BINARY_EN
    assign word_in = {~adc_data[DATA_BUS_SIZE-1], adc_data[DATA_BUS_SIZE-2:0]};
`else
    assign word_in = adc_data;
`endif

    // A marker always restarts the frame at slot 0.
    assign wr_idx = adc_first ? 2'd0 : index;

    always_comb begin
        state_nxt    = state;
        index_nxt    = index;
        idle_cnt_nxt = idle_cnt;
        store        = 1'b0;
        abort        = 1'b0;
        complete     = 1'b0;
        case (state)
            SYNC_WAIT: begin
                idle_cnt_nxt = '0;
                if (adc_valid && adc_first) begin
                    store     = 1'b1;
                    index_nxt = 2'd1;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (adc_valid) begin
                    idle_cnt_nxt = '0;
                    store        = 1'b1;
                    if (adc_first) begin
                        abort     = 1'b1;
                        index_nxt = 2'd1;
                    end else if (index == 2'd3) begin
                        complete  = 1'b1;
                        index_nxt = 2'd0;
                        state_nxt = SYNC_WAIT;
                    end else begin
                        index_nxt = index + 2'd1;
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    abort        = 1'b1;
                    idle_cnt_nxt = '0;
                    index_nxt    = 2'd0;
                    state_nxt    = SYNC_WAIT;
                end else begin
                    idle_cnt_nxt = idle_cnt + 16'd1;
                end
            end
            default: state_nxt = SYNC_WAIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= SYNC_WAIT;
            index    <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            index    <= index_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    // Outputs are copied from staging one edge after word 3, so a new word 0 may land in slot 0 on that same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) slot[i] <= '0;
            complete_q      <= 1'b0;
            signalChannel_I <= '0;
            signalChannel_Q <= '0;
            noiseChannel_I  <= '0;
            noiseChannel_Q  <= '0;
            sigEnable       <= 1'b0;
            frame_error     <= 1'b0;
            dropped_frames  <= '0;
        end else begin
            if (store) slot[wr_idx] <= word_in;
            complete_q  <= complete;
            sigEnable   <= complete_q;
            frame_error <= abort;
            if (complete_q) begin
                signalChannel_I <= slot[0];
                signalChannel_Q <= slot[1];
                noiseChannel_I  <= slot[2];
                noiseChannel_Q  <= slot[3];
            end
            if (abort && dropped_frames != 16'hFFFF) dropped_frames <= dropped_frames + 16'd1;
        end
    end

endmodule

// File: tb/tb_anc_sample_deinterleaver.sv
// Randomized and directed bench for anc_sample_deinterleaver against a frame-level queue model.
// Honours ANC_OFFSET_BINARY_EN in both the model and a dedicated directed frame.
module tb_anc_sample_deinterleaver;

    localparam int W  = 12;
    localparam int TO = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] adc_data;
    logic         adc_valid;
    logic         adc_first;
    logic [W-1:0] s_i, s_q, n_i, n_q;
    logic         sigEnable;
    logic         frame_error;
    logic [15:0]  dropped_frames;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words of the open frame, last completed frame, visible outputs.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_done [4];
    logic [W-1:0] m_out  [4];
    logic         m_pend, m_sig, m_err;
    int           m_idle, m_drop;

    anc_sample_deinterleaver #(.DATA_BUS_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
        .clock           (clock),
        .reset           (reset),
        .adc_data        (adc_data),
        .adc_valid       (adc_valid),
        .adc_first       (adc_first),
        .signalChannel_I (s_i),
        .signalChannel_Q (s_q),
        .noiseChannel_I  (n_i),
        .noiseChannel_Q  (n_q),
        .sigEnable       (sigEnable),
        .frame_error     (frame_error),
        .dropped_frames  (dropped_frames)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] conv(input logic [W-1:0] d);
`ifdef ANC_OFFSET_BINARY_EN
        return {~d[W-1], d[W-2:0]};
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) begin
            m_done[i] = '0;
            m_out[i]  = '0;
        end
        m_pend = 1'b0;
        m_sig  = 1'b0;
        m_err  = 1'b0;
        m_idle = 0;
        m_drop = 0;
    endtask

    task automatic model_abort();
        m_err = 1'b1;
        if (m_drop < 65535) m_drop++;
        m_q.delete();
        m_idle = 0;
    endtask

    task automatic model_step(input logic v, input logic f, input logic [W-1:0] d);
        m_sig = m_pend;
        m_err = 1'b0;
        if (m_pend) m_out = m_done;
        m_pend = 1'b0;
        if (v && f) begin
            if (m_q.size() > 0) model_abort();
            m_q.push_back(conv(d));
            m_idle = 0;
        end else if (v && m_q.size() > 0) begin
            m_q.push_back(conv(d));
            m_idle = 0;
            if (m_q.size() == 4) begin
                for (int i = 0; i < 4; i++) m_done[i] = m_q[i];
                m_pend = 1'b1;
                m_q.delete();
            end
        end else if (!v && m_q.size() > 0) begin
            m_idle++;
            if (m_idle == TO) model_abort();
        end
    endtask

    task automatic compare_all();
        check("sigEnable", 32'(sigEnable), 32'(m_sig));
        check("frame_error", 32'(frame_error), 32'(m_err));
        check("dropped_frames", 32'(dropped_frames), 32'(m_drop));
        check("signalChannel_I", 32'(s_i), 32'(m_out[0]));
        check("signalChannel_Q", 32'(s_q), 32'(m_out[1]));
        check("noiseChannel_I", 32'(n_i), 32'(m_out[2]));
        check("noiseChannel_Q", 32'(n_q), 32'(m_out[3]));
    endtask

    task automatic cyc(input logic v, input logic f, input logic [W-1:0] d);
        adc_valid = v;
        adc_first = f;
        adc_data  = d;
        @(posedge clock);
        model_step(v, f, d);
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        model_reset();
        compare_all();
        #1 reset = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] e);
        check({tag, "_sI"}, 32'(s_i), 32'(a));
        check({tag, "_sQ"}, 32'(s_q), 32'(b));
        check({tag, "_nI"}, 32'(n_i), 32'(c));
        check({tag, "_nQ"}, 32'(n_q), 32'(e));
    endtask

    initial begin
        adc_valid = 1'b0;
        adc_first = 1'b0;
        adc_data  = '0;
        reset     = 1'b1;
        #3;
        model_reset();
        compare_all();
        #4 reset = 1'b0;

        // Full-rate frame
        cyc(1, 1, 12'h123);
        cyc(1, 0, 12'h456);
        cyc(1, 0, 12'h789);
        cyc(1, 0, 12'hABC);
        check("t1_sig_before", 32'(sigEnable), 32'd0);
        cyc(0, 0, 12'h000);
        check("t1_sig", 32'(sigEnable), 32'd1);
        check("t1_err", 32'(frame_error), 32'd0);
        check("t1_drop", 32'(dropped_frames), 32'd0);
        check_outs("t1", conv(12'h123), conv(12'h456), conv(12'h789), conv(12'hABC));
        cyc(0, 0, 12'h000);
        check("t1_sig_once", 32'(sigEnable), 32'd0);

        // Marker arriving mid-frame
        cyc(1, 1, 12'h111);
        cyc(1, 0, 12'h222);
        cyc(1, 1, 12'h333);
        check("t2_err", 32'(frame_error), 32'd1);
        check("t2_drop", 32'(dropped_frames), 32'd1);
        cyc(1, 0, 12'h444);
        check("t2_err_once", 32'(frame_error), 32'd0);
        cyc(1, 0, 12'h555);
        cyc(1, 0, 12'h666);
        cyc(0, 0, 12'h000);
        check("t2_sig", 32'(sigEnable), 32'd1);
        check_outs("t2", conv(12'h333), conv(12'h444), conv(12'h555), conv(12'h666));

        // Stall of TO cycles aborts; outputs keep the last good frame
        cyc(1, 1, 12'h010);
        cyc(1, 0, 12'h020);
        for (int i = 0; i < TO; i++) cyc(0, 0, 12'h000);
        check("t3_err", 32'(frame_error), 32'd1);
        check("t3_drop", 32'(dropped_frames), 32'd2);
        check_outs("t3_hold", conv(12'h333), conv(12'h444), conv(12'h555), conv(12'h666));
        cyc(1, 1, 12'h010);
        cyc(1, 0, 12'h020);
        for (int i = 0; i < TO - 1; i++) cyc(0, 0, 12'h000);
        cyc(1, 0, 12'h030);
        check("t3_no_timeout", 32'(frame_error), 32'd0);
        cyc(1, 0, 12'h040);
        cyc(0, 0, 12'h000);
        check("t3_sig", 32'(sigEnable), 32'd1);
        check_outs("t3", conv(12'h010), conv(12'h020), conv(12'h030), conv(12'h040));

        // Stray words, then reset in the middle of a frame
        for (int i = 0; i < 3; i++) cyc(1, 0, 12'h7FF);
        cyc(0, 1, 12'h7FF);
        check("t4_stray_err", 32'(frame_error), 32'd0);
        cyc(1, 1, 12'h0AA);
        cyc(1, 0, 12'h0BB);
        pulse_reset();
        check_outs("t4_rst", 12'h000, 12'h000, 12'h000, 12'h000);
        check("t4_rst_drop", 32'(dropped_frames), 32'd0);
        cyc(1, 0, 12'h0CC);
        cyc(1, 1, 12'h0A1);
        cyc(1, 0, 12'h0A2);
        cyc(1, 0, 12'h0A3);
        cyc(1, 0, 12'h0A4);
        cyc(1, 1, 12'h0B1);
        check("t4_sig_b2b", 32'(sigEnable), 32'd1);
        check_outs("t4", conv(12'h0A1), conv(12'h0A2), conv(12'h0A3), conv(12'h0A4));

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic v, f;
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 7) == 0);
            cyc(v, f, W'($urandom));
        end

        // Repeated markers saturate the drop counter
        pulse_reset();
        for (int i = 0; i < 65538; i++) cyc(1, 1, W'($urandom));
        check("sat_drop", 32'(dropped_frames), 32'h0000FFFF);
        cyc(1, 1, 12'h001);
        check("sat_err", 32'(frame_error), 32'd1);
        check("sat_hold", 32'(dropped_frames), 32'h0000FFFF);

`ifdef ANC_OFFSET_BINARY_EN
        pulse_reset();
        cyc(1, 1, 12'h800);
        cyc(1, 0, 12'h000);
        cyc(1, 0, 12'hFFF);
        cyc(1, 0, 12'h801);
        cyc(0, 0, 12'h000);
        check("ob_sig", 32'(sigEnable), 32'd1);
        check_outs("ob", 12'h000, 12'h800, 12'h7FF, 12'h001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
